// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 16-bit, 4-bit-opcode five-stage CPU.
//   - opcode encodings
//   - hazard controller state type
//   - uses_rs / uses_rt: which register fields an opcode actually reads
package cpu_pkg;

    localparam int OPCODE_W = 4;
    localparam int REG_W    = 4;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LHB    = 4'b1010;
    localparam logic [3:0] OP_LLB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    typedef enum logic [1:0] {RUN, BR_STALL, DRAIN, HALTED} hz_state_t;

    // rs field is read by every ALU/memory/LHB/LLB opcode and by BR.
    function automatic logic uses_rs(input logic [3:0] op);
        return (op <= OP_LLB) || (op == OP_BR);
    endfunction

    // rt field is read only by the two-source ALU ops and by SW (store data).
    function automatic logic uses_rt(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_XOR) ||
               (op == OP_RED) || (op == OP_PADDSB) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational classification of the IF/ID instruction
// against the ID/EX destination.
//   in : idValid, idOpcode, idRs, idRt, exRegWrite, exMemToReg, exRd
//   out: brStall (BR reading a register still being produced in EX),
//        loadUse (load in EX feeds a source of the IF/ID instruction),
//        hltReq  (valid HLT sitting in IF/ID)
module hazard_detect
    import cpu_pkg::*;
(
    input  logic             idValid,
    input  logic [3:0]       idOpcode,
    input  logic [REG_W-1:0] idRs,
    input  logic [REG_W-1:0] idRt,
    input  logic             exRegWrite,
    input  logic             exMemToReg,
    input  logic [REG_W-1:0] exRd,
    output logic             brStall,
    output logic             loadUse,
    output logic             hltReq
);

    logic exRdNz;
    logic match;

    // R0 is hardwired to zero, so a write to it is never a real dependency.
    assign exRdNz  = (exRd != '0);
    assign match   = exRdNz && ((uses_rs(idOpcode) && (exRd == idRs)) ||
                                (uses_rt(idOpcode) && (exRd == idRt)));

    // BR resolves in ID, so any producer in EX (ALU or load) forces a wait.
    assign brStall = idValid && (idOpcode == OP_BR) && exRegWrite &&
                     exRdNz && (exRd == idRs);
    assign loadUse = idValid && exMemToReg && exRegWrite && match;
    assign hltReq  = idValid && (idOpcode == OP_HLT);

endmodule

// File: rtl/hazard_flush_ctrl.sv
// hazard_flush_ctrl: pipeline stall/flush controller.
//   clk, rst_n          : clock, async active-low reset
//   id_*                : instruction in IF/ID
//   ex_*                : destination info held in ID/EX
//   branch_taken        : ID-stage branch resolved taken
//   pc_write/if_id_write: front-end enables (0 = hold)
//   if_flush            : squash IF/ID on the next edge
//   id_flush            : force a bubble into ID/EX
//   halted              : sticky, pipeline drained after HLT
module hazard_flush_ctrl
    import cpu_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int REG_W        = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic                ex_reg_write,
    input  logic                ex_mem_to_reg,
    input  logic [REG_W-1:0]    ex_rd,
    input  logic                branch_taken,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                if_flush,
    output logic                id_flush,
    output logic                halted
);

    localparam int CNT_RAW = $clog2(DRAIN_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 2) ? 2 : CNT_RAW;

    hz_state_t        state, stateNxt;
    logic [CNT_W-1:0] cnt, cntNxt;
    logic             haltedNxt;
    logic             brStall, loadUse, hltReq;

    hazard_detect uDetect (
        .idValid    (id_valid),
        .idOpcode   (id_opcode),
        .idRs       (id_rs),
        .idRt       (id_rt),
        .exRegWrite (ex_reg_write),
        .exMemToReg (ex_mem_to_reg),
        .exRd       (ex_rd),
        .brStall    (brStall),
        .loadUse    (loadUse),
        .hltReq     (hltReq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            cnt    <= '0;
            halted <= 1'b0;
        end else begin
            state  <= stateNxt;
            cnt    <= cntNxt;
            halted <= haltedNxt;
        end
    end

    always_comb begin
        stateNxt    = state;
        cntNxt      = cnt;
        haltedNxt   = halted;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_flush    = 1'b0;
        id_flush    = 1'b0;
        case (state)
            RUN: begin
                if (brStall) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_flush    = 1'b1;
                    // A load producer needs one more cycle beyond an ALU one;
                    // an ALU producer simply re-evaluates next cycle in RUN.
                    if (ex_mem_to_reg) begin
                        stateNxt = BR_STALL;
                        cntNxt   = CNT_W'(1);
                    end
                end else if (loadUse) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_flush    = 1'b1;
                end else if (branch_taken) begin
                    if_flush = 1'b1;
                end else if (hltReq) begin
                    // HLT itself proceeds to EX; the front end freezes.
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    stateNxt    = DRAIN;
                    cntNxt      = CNT_W'(DRAIN_CYCLES);
                end
            end
            BR_STALL, DRAIN: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_flush    = 1'b1;
                cntNxt      = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    if (state == DRAIN) begin
                        stateNxt  = HALTED;
                        haltedNxt = 1'b1;
                    end else begin
                        stateNxt = RUN;
                    end
                end
            end
            HALTED: begin
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                id_flush    = 1'b1;
            end
            default: stateNxt = RUN;
        endcase
    end

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
module tb_hazard_flush_ctrl;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, ex_reg_write, ex_mem_to_reg, branch_taken;
    logic [3:0] id_opcode, id_rs, id_rt, ex_rd;
    logic       pc_write, if_id_write, if_flush, id_flush, halted;
    logic [4:0] outs;

    int nChk  = 0;
    int nFail = 0;

    // Expected {pc_write, if_id_write, if_flush, id_flush, halted}
    localparam logic [4:0] E_RUN   = 5'b11000;
    localparam logic [4:0] E_STALL = 5'b00010;
    localparam logic [4:0] E_TAKEN = 5'b11100;
    localparam logic [4:0] E_HLT   = 5'b00000;
    localparam logic [4:0] E_HALT  = 5'b00011;

    typedef struct packed {
        logic       v;
        logic [3:0] op, rs, rt;
        logic       erw, emr;
        logic [3:0] erd;
        logic       bt;
        logic [4:0] exp;
    } stim_t;

    logic [4:0] expQ[$];

    always #5 clk = ~clk;

    assign outs = {pc_write, if_id_write, if_flush, id_flush, halted};

    hazard_flush_ctrl #(.OPCODE_W(4), .REG_W(4), .DRAIN_CYCLES(3)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_rd         (ex_rd),
        .branch_taken  (branch_taken),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_flush      (if_flush),
        .id_flush      (id_flush),
        .halted        (halted)
    );

    function automatic stim_t mk(input logic v, input logic [3:0] op, rs, rt,
                                 input logic erw, emr, input logic [3:0] erd,
                                 input logic bt, input logic [4:0] exp);
        return '{v, op, rs, rt, erw, emr, erd, bt, exp};
    endfunction

    function automatic stim_t mkRand(input logic [4:0] exp);
        return '{1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), exp};
    endfunction

    // Applies one cycle of stimulus and queues what the outputs must be.
    task automatic drive(input stim_t s);
        id_valid      = s.v;
        id_opcode     = s.op;
        id_rs         = s.rs;
        id_rt         = s.rt;
        ex_reg_write  = s.erw;
        ex_mem_to_reg = s.emr;
        ex_rd         = s.erd;
        branch_taken  = s.bt;
        expQ.push_back(s.exp);
    endtask

    task automatic test_reset;
        logic [4:0] want;
        rst_n = 1'b0;
        drive(mk(0, OP_ADD, 0, 0, 0, 0, 0, 0, E_RUN));
        #12;
        want = expQ.pop_front();
        nChk++;
        if (outs !== want) begin
            nFail++;
            $display("FAIL reset_async: got %b want %b", outs, want);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(mk(0, OP_ADD, 0, 0, 1, 1, 3, 0, E_RUN));
        @(negedge clk);
        want = expQ.pop_front();
        nChk++;
        if (outs !== want) begin
            nFail++;
            $display("FAIL reset_release: got %b want %b", outs, want);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use;
        stim_t t[$];
        logic [4:0] want;
        t.push_back(mk(1, OP_ADD, 1, 3, 1, 1, 3, 0, E_STALL)); // rt hit
        t.push_back(mk(1, OP_ADD, 1, 3, 0, 0, 0, 0, E_RUN));   // ex bubbled
        t.push_back(mk(1, OP_SUB, 3, 2, 1, 1, 3, 1, E_STALL)); // rs hit, bt ignored
        t.push_back(mk(1, OP_LW,  1, 3, 1, 1, 3, 0, E_RUN));   // LW ignores rt
        t.push_back(mk(1, OP_SW,  1, 3, 1, 1, 3, 0, E_STALL)); // SW reads rt
        t.push_back(mk(0, OP_ADD, 3, 3, 1, 1, 3, 0, E_RUN));   // not valid
        t.push_back(mk(1, OP_ADD, 3, 3, 0, 1, 3, 0, E_RUN));   // no RegWrite
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = expQ.pop_front();
            nChk++;
            if (outs !== want) begin
                nFail++;
                $display("FAIL load_use step%0d: got %b want %b", i, outs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_r0;
        stim_t t[$];
        logic [4:0] want;
        t.push_back(mk(1, OP_ADD, 0, 0, 1, 1, 0, 0, E_RUN));
        t.push_back(mk(1, OP_BR,  0, 0, 1, 1, 0, 0, E_RUN));
        t.push_back(mk(1, OP_ADD, 0, 0, 0, 0, 0, 0, E_RUN));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = expQ.pop_front();
            nChk++;
            if (outs !== want) begin
                nFail++;
                $display("FAIL r0 step%0d: got %b want %b", i, outs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_br_stall;
        stim_t t[$];
        logic [4:0] want;
        // BR on a load: two stall cycles, taken ignored until the stall clears
        t.push_back(mk(1, OP_BR, 5, 0, 1, 1, 5, 1, E_STALL));
        t.push_back(mk(1, OP_BR, 5, 0, 0, 0, 0, 1, E_STALL));
        t.push_back(mk(1, OP_BR, 5, 0, 0, 0, 0, 1, E_TAKEN));
        t.push_back(mk(1, OP_ADD, 1, 2, 0, 0, 0, 0, E_RUN));
        // BR on an ALU result: one stall cycle
        t.push_back(mk(1, OP_BR, 7, 0, 1, 0, 7, 1, E_STALL));
        t.push_back(mk(1, OP_BR, 7, 0, 0, 0, 0, 1, E_TAKEN));
        t.push_back(mk(1, OP_ADD, 1, 2, 0, 0, 0, 0, E_RUN));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = expQ.pop_front();
            nChk++;
            if (outs !== want) begin
                nFail++;
                $display("FAIL br_stall step%0d: got %b want %b", i, outs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_taken_branch;
        stim_t t[$];
        logic [4:0] want;
        t.push_back(mk(1, OP_B,   0, 0, 1, 0, 4, 1, E_TAKEN));
        t.push_back(mk(1, OP_ADD, 1, 2, 0, 0, 0, 0, E_RUN));
        t.push_back(mk(1, OP_HLT, 0, 0, 0, 0, 0, 1, E_TAKEN)); // branch beats HLT
        t.push_back(mk(1, OP_ADD, 1, 2, 0, 0, 0, 0, E_RUN));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = expQ.pop_front();
            nChk++;
            if (outs !== want) begin
                nFail++;
                $display("FAIL taken_branch step%0d: got %b want %b", i, outs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hlt_drain;
        stim_t t[$];
        logic [4:0] want;
        t.push_back(mk(1, OP_HLT, 0, 0, 0, 0, 0, 0, E_HLT));
        for (int k = 0; k < 3; k++) t.push_back(mkRand(E_STALL));
        for (int k = 0; k < 6; k++) t.push_back(mkRand(E_HALT));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = expQ.pop_front();
            nChk++;
            if (outs !== want) begin
                nFail++;
                $display("FAIL hlt_drain step%0d: got %b want %b", i, outs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_drain;
        stim_t t[$];
        logic [4:0] want;
        rst_n = 1'b0;
        drive(mk(0, OP_ADD, 0, 0, 0, 0, 0, 0, E_RUN));
        @(negedge clk);
        want = expQ.pop_front();
        nChk++;
        if (outs !== want) begin
            nFail++;
            $display("FAIL mid_drain_prereset: got %b want %b", outs, want);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        t.push_back(mk(1, OP_HLT, 0, 0, 0, 0, 0, 0, E_HLT));
        t.push_back(mk(0, OP_ADD, 0, 0, 0, 0, 0, 0, E_STALL));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = expQ.pop_front();
            nChk++;
            if (outs !== want) begin
                nFail++;
                $display("FAIL mid_drain_enter step%0d: got %b want %b", i, outs, want);
            end
            @(posedge clk); #1;
        end
        // Still draining here; drop reset between edges.
        drive(mk(0, OP_ADD, 0, 0, 0, 0, 0, 0, E_RUN));
        #2 rst_n = 1'b0;
        #1;
        want = expQ.pop_front();
        nChk++;
        if (outs !== want) begin
            nFail++;
            $display("FAIL mid_drain_async: got %b want %b", outs, want);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        t.delete();
        t.push_back(mk(1, OP_ADD, 1, 2, 1, 0, 6, 0, E_RUN));
        t.push_back(mk(1, OP_ADD, 6, 2, 1, 1, 6, 0, E_STALL));
        t.push_back(mk(1, OP_ADD, 6, 2, 0, 0, 0, 0, E_RUN));
        t.push_back(mk(1, OP_B,   0, 0, 0, 0, 0, 1, E_TAKEN));
        foreach (t[i]) begin
            drive(t[i]);
            @(negedge clk);
            want = expQ.pop_front();
            nChk++;
            if (outs !== want) begin
                nFail++;
                $display("FAIL mid_drain_resume step%0d: got %b want %b", i, outs, want);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_use();
        test_r0();
        test_br_stall();
        test_taken_branch();
        test_hlt_drain();
        test_reset_mid_drain();
        nChk++;
        if (expQ.size() != 0) begin
            nFail++;
            $display("FAIL scoreboard_drain: got %0d left want 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
